sram_access_arbiter: RTL and testbench

Shares the single external 1Mx16 SRAM between two requesters: the SLC-3 CPU memory path (port 0, MAR/MDR side) and a program loader/debug port (port 1). It arbitrates round-robin, runs a fixed-length read or write cycle, and generates the active-low SRAM strobes and the tristate drive enable. Read data is captured per port. It sits between the requesters and the SRAM tristate interface, in place of direct strobe generation by the control unit.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/sram_access_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_access_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    // Upper SRAM address bits; the requesters only reach the low 64K words.
    localparam logic [3:0] SRAM_ADDR_PAD = 4'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a sole requester wins, and under contention
// the port that did not win last time gets the grant.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,   // index of the previous winner
    output logic [1:0] gnt_o
);

    // One-hot grant from the request pair and the previous winner
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one asynchronous 1Mx16 SRAM between the CPU memory path (port 0)
// and the loader/debug port (port 1). Each access runs a fixed
// SETUP / ACCESS(WAIT_CYCLES) / HOLD sequence. All strobes are decoded from
// registered state, so an asynchronous reset releases them immediately.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [15:0]       ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [19:0]       ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              sram_drive,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 1) begin : g_wait_chk
        $error("sram_access_arbiter: WAIT_CYCLES must be >= 1");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          grant_q, grant_d;
    logic                last_q;          // 1 = loader won the previous arbitration
    logic [15:0]         addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q, ldr_rdata_q;
    logic [1:0]          gnt;
    logic                start;
    logic                last_access;

    rr_arbiter2 u_rr (
        .req_i        ({ldr_req, cpu_req}),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    assign start       = (state_q == IDLE) && (gnt != 2'b00);
    assign last_access = (state_q == ACCESS) && (cnt_q == CNT_W'(1));

    // FSM state, wait counter and current owner
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // Request latch at grant time and per-port read-data capture
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q      <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (start) begin
                last_q  <= gnt[PORT_LDR];
                addr_q  <= gnt[PORT_CPU] ? cpu_addr  : ldr_addr;
                we_q    <= gnt[PORT_CPU] ? cpu_we    : ldr_we;
                wdata_q <= gnt[PORT_CPU] ? cpu_wdata : ldr_wdata;
            end
            if (last_access && !we_q) begin
                if (grant_q[PORT_CPU]) cpu_rdata_q <= Data_from_SRAM;
                if (grant_q[PORT_LDR]) ldr_rdata_q <= Data_from_SRAM;
            end
        end
    end

    // Next state and strobe decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        busy         = (state_q != IDLE);
        CE           = 1'b1;
        UB           = 1'b1;
        LB           = 1'b1;
        OE           = 1'b1;
        WE           = 1'b1;
        sram_drive   = 1'b0;
        cpu_ack      = 1'b0;
        ldr_ack      = 1'b0;
        ADDR         = {SRAM_ADDR_PAD, addr_q};
        Data_to_SRAM = wdata_q;
        grant        = grant_q;
        cpu_rdata    = cpu_rdata_q;
        ldr_rdata    = ldr_rdata_q;

        // Chip and byte enables stay low across the whole access; the FPGA
        // drives the data bus from SETUP through HOLD on writes.
        if (busy) begin
            CE         = 1'b0;
            UB         = 1'b0;
            LB         = 1'b0;
            sram_drive = we_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    grant_d = gnt;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES);
            end
            ACCESS: begin
                OE = we_q;
                WE = !we_q;
                if (cnt_q == CNT_W'(1)) state_d = HOLD;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            HOLD: begin
                cpu_ack = grant_q[PORT_CPU];
                ldr_ack = grant_q[PORT_LDR];
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: main instance at WAIT_CYCLES=2,
// a second instance at WAIT_CYCLES=1 for back-to-back latency.
module tb_sram_access_arbiter;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    // ---------------- instance A (WAIT_CYCLES=2) ----------------
    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic        cpu_ack, ldr_ack, sram_drive, CE, UB, LB, OE, WE, busy;
    logic [15:0] cpu_rdata, ldr_rdata, Data_to_SRAM, Data_from_SRAM;
    logic [19:0] ADDR;
    logic [1:0]  grant;
    logic [15:0] mem_a [256];

    assign Data_from_SRAM = OE ? 16'hzzzz : mem_a[ADDR[7:0]];
    always @(posedge Clk) if (!WE && !CE) mem_a[ADDR[7:0]] <= Data_to_SRAM;

    sram_access_arbiter #(.WAIT_CYCLES(2), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .sram_drive(sram_drive), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .grant(grant), .busy(busy)
    );

    // ---------------- instance B (WAIT_CYCLES=1) ----------------
    logic        b_cpu_req = 0, b_cpu_we = 0, b_ldr_req = 0, b_ldr_we = 0;
    logic [15:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_ldr_addr = 0, b_ldr_wdata = 0;
    logic        b_cpu_ack, b_ldr_ack, b_drive, b_CE, b_UB, b_LB, b_OE, b_WE, b_busy;
    logic [15:0] b_cpu_rdata, b_ldr_rdata, b_d2s, b_dfs;
    logic [19:0] b_ADDR;
    logic [1:0]  b_grant;
    logic [15:0] mem_b [256];

    assign b_dfs = b_OE ? 16'hzzzz : mem_b[b_ADDR[7:0]];
    always @(posedge Clk) if (!b_WE && !b_CE) mem_b[b_ADDR[7:0]] <= b_d2s;

    sram_access_arbiter #(.WAIT_CYCLES(1), .DATA_W(16)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .ADDR(b_ADDR), .Data_to_SRAM(b_d2s), .Data_from_SRAM(b_dfs),
        .sram_drive(b_drive), .CE(b_CE), .UB(b_UB), .LB(b_LB), .OE(b_OE), .WE(b_WE),
        .grant(b_grant), .busy(b_busy)
    );

    // ---------------- checking ----------------
    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: one entry per expected ack, carrying the port and the
    // rdata that port must show once the ack arrives.
    typedef struct {
        int          port;
        logic [15:0] rd;
    } exp_t;
    exp_t        sbq[$];
    logic [15:0] exp_rd [2];

    task automatic push(input int port, input bit is_read, input logic [15:0] val);
        exp_t e;
        if (is_read) exp_rd[port] = val;
        e.port = port;
        e.rd   = exp_rd[port];
        sbq.push_back(e);
    endtask

    always @(negedge Clk) begin : mon
        exp_t e;
        if (!Reset && (cpu_ack || ldr_ack)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ack", {30'b0, ldr_ack, cpu_ack}, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk("sb_ack_port", {30'b0, ldr_ack, cpu_ack}, (e.port == 0) ? 32'h1 : 32'h2);
                chk("sb_rdata", (e.port == 0) ? cpu_rdata : ldr_rdata, e.rd);
            end
        end
    end

    // Per-cycle trace of instance A; cycle c is sampled at its falling edge.
    logic [31:0] ce_t, oe_t, we_t, drv_t, cack_t, lack_t, busy_t;
    logic [19:0] addr_t [32];
    logic [1:0]  gnt_t  [32];
    logic [15:0] d2s_t  [32];

    task automatic trace(input int n, input bit hold, input int chg);
        ce_t = '0; oe_t = '0; we_t = '0; drv_t = '0;
        cack_t = '0; lack_t = '0; busy_t = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge Clk);
            ce_t[c]   = !CE;
            oe_t[c]   = !OE;
            we_t[c]   = !WE;
            drv_t[c]  = sram_drive;
            cack_t[c] = cpu_ack;
            lack_t[c] = ldr_ack;
            busy_t[c] = busy;
            addr_t[c] = ADDR;
            gnt_t[c]  = grant;
            d2s_t[c]  = Data_to_SRAM;
            @(posedge Clk);
            #1;
            if (!hold && cack_t[c]) cpu_req = 1'b0;
            if (!hold && lack_t[c]) ldr_req = 1'b0;
            if (c + 1 == chg) cpu_addr = 16'h0099;
        end
    endtask

    int          bad;
    logic [31:0] bm, bwe;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;

        // reset state
        #12;
        chk("rst_CE", CE, 1);
        chk("rst_UB_LB", {UB, LB}, 2'b11);
        chk("rst_OE_WE", {OE, WE}, 2'b11);
        chk("rst_drive", sram_drive, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        chk("rst_ADDR", ADDR, 0);
        chk("rst_d2s", Data_to_SRAM, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // 1: CPU read of 0x0010
        mem_a[8'h10] = 16'hBEEF;
        mem_a[8'h99] = 16'hDEAD;
        cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
        push(0, 1, 16'hBEEF);
        trace(8, 0, 0);
        chk("t1_ADDR", addr_t[1], 20'h00010);
        chk("t1_CE_low", ce_t, 32'h1E);
        chk("t1_OE_low", oe_t, 32'h0C);
        chk("t1_WE_low", we_t, 32'h0);
        chk("t1_cpu_ack", cack_t, 32'h10);
        chk("t1_busy", busy_t, 32'h1E);
        chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_ldr_rdata", ldr_rdata, 16'h0);

        // 2: loader write of 0x1234 to 0x0020
        ldr_we = 1; ldr_addr = 16'h0020; ldr_wdata = 16'h1234; ldr_req = 1;
        push(1, 0, 16'h0);
        trace(8, 0, 0);
        chk("t2_WE_low", we_t, 32'h0C);
        chk("t2_OE_low", oe_t, 32'h0);
        chk("t2_drive", drv_t, 32'h1E);
        chk("t2_d2s", d2s_t[1], 16'h1234);
        chk("t2_ldr_ack", lack_t, 32'h10);
        chk("t2_cpu_ack", cack_t, 32'h0);
        chk("t2_mem", mem_a[8'h20], 16'h1234);

        // 3: both requesters held high -> strict alternation, CPU first
        mem_a[8'h30] = 16'h1111;
        mem_a[8'h40] = 16'h2222;
        cpu_we = 0; cpu_addr = 16'h0030; ldr_we = 0; ldr_addr = 16'h0040;
        cpu_req = 1; ldr_req = 1;
        push(0, 1, 16'h1111); push(1, 1, 16'h2222);
        push(0, 1, 16'h1111); push(1, 1, 16'h2222);
        trace(20, 1, 0);
        cpu_req = 0; ldr_req = 0;
        chk("t3_cpu_acks", cack_t, 32'h0000_4010);
        chk("t3_ldr_acks", lack_t, 32'h0008_0200);
        chk("t3_gnt0", gnt_t[1], 2'b01);
        chk("t3_gnt1", gnt_t[6], 2'b10);
        chk("t3_gnt2", gnt_t[11], 2'b01);
        chk("t3_gnt3", gnt_t[16], 2'b10);
        chk("t3_rdata", {cpu_rdata, ldr_rdata}, 32'h1111_2222);

        // 6: requester moves its address mid-access
        cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
        push(0, 1, 16'hBEEF);
        trace(8, 0, 2);
        bad = 0;
        for (int c = 1; c <= 4; c++) if (addr_t[c] !== 20'h00010) bad++;
        chk("t6_addr_stable", bad, 0);
        chk("t6_rdata", cpu_rdata, 16'hBEEF);

        // 4: reset during ACCESS of a CPU write (CPU won last, so loader
        // would win next without the reset)
        cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 16'h55AA; cpu_req = 1;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        chk("t4_WE_pre", WE, 0);
        #2;
        Reset = 1'b1;
        #1;
        chk("t4_WE_async", WE, 1);
        chk("t4_CE_async", CE, 1);
        chk("t4_drive_async", sram_drive, 0);
        chk("t4_busy_async", busy, 0);
        chk("t4_ack", {cpu_ack, ldr_ack}, 0);
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        @(posedge Clk);
        #1;
        chk("t4_rdata_rst", {cpu_rdata, ldr_rdata}, 0);
        cpu_we = 0; cpu_addr = 16'h0010;
        ldr_we = 0; ldr_addr = 16'h0040; ldr_req = 1;
        Reset = 1'b0;
        push(0, 1, 16'hBEEF); push(1, 1, 16'h2222);
        trace(12, 0, 0);
        chk("t4_first_gnt", gnt_t[1], 2'b01);
        chk("t4_cpu_ack", cack_t, 32'h10);
        chk("t4_ldr_ack", lack_t, 32'h200);

        // 5: WAIT_CYCLES=1, CPU read then CPU write back-to-back
        mem_b[8'h10] = 16'h7777;
        b_cpu_we = 0; b_cpu_addr = 16'h0010; b_cpu_req = 1;
        bm = '0; bwe = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            bm[c]  = b_cpu_ack;
            bwe[c] = !b_WE;
            @(posedge Clk);
            #1;
            if (c == 3) begin
                b_cpu_we = 1; b_cpu_addr = 16'h0011; b_cpu_wdata = 16'h3333;
            end
            if (c == 7) b_cpu_req = 0;
        end
        chk("t5_acks", bm, 32'h88);
        chk("t5_WE_low", bwe, 32'h40);
        chk("t5_rdata", b_cpu_rdata, 16'h7777);
        chk("t5_mem", mem_b[8'h11], 16'h3333);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
